decimal_counter_ctrl: RTL and testbench

Command sequencer and arbiter for the synchronous BCD decimal counter. It accepts START/STOP/LOAD commands from two independent requesters over valid/ready handshakes and arbitrates them round-robin. It drives the counter's load, direction and per-step enable from a 4-state FSM and a programmable prescaler. It also watches the counter's BCD value to stop or reverse at the terminal counts 99 and 00.

---
 rtl/decimal_counter_ctrl.sv | 165 ++++++++++++++++
 tb/tb_decimal_counter_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decimal_counter_ctrl.sv
// decimal_counter_ctrl: round-robin START/STOP/LOAD sequencer driving a BCD counter's load, direction and step enable.
// Latency: an accepted command changes state at the same edge; in RUN a step is issued every PRESCALE cycles.
// Backpressure: ready is the arbiter grant, withheld during the one-cycle LOAD state; the losing requester holds valid.
module decimal_counter_ctrl #(
  parameter int PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a_valid,
  input  logic [1:0] req_a_cmd,
  output logic       req_a_ready,
  input  logic       req_b_valid,
  input  logic [1:0] req_b_cmd,
  output logic       req_b_ready,
  input  logic       auto_reverse,
  input  logic [7:0] count_bcd,
  output logic       cnt_load,
  output logic       cnt_up_down,
  output logic       cnt_step,
  output logic       done,
  output logic [1:0] state
);

  localparam int            PW         = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_RUN   = 2'b10,
    S_PAUSE = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          dir_q, dir_d;
  logic          load_q, load_d;
  logic          step_q, step_d;
  logic          done_q, done_d;
  logic          rr_q, rr_d;      // 0: A wins a contested cycle, 1: B wins

  logic          gnt_a, gnt_b;
  logic          acc;
  logic [1:0]    cmd;
  logic          is_load_cmd;
  logic          slot;
  logic          terminal;

  // Round-robin grant: a lone requester always wins, contention is settled by rr_q.
  always_comb begin
    gnt_a = req_a_valid && (!req_b_valid || !rr_q);
    gnt_b = req_b_valid && (!req_a_valid ||  rr_q);
  end

  assign req_a_ready = gnt_a && (state_q != S_LOAD);
  assign req_b_ready = gnt_b && (state_q != S_LOAD);
  assign acc         = req_a_ready || req_b_ready;
  assign cmd         = req_a_ready ? req_a_cmd : req_b_cmd;
  assign is_load_cmd = cmd[1];

  // A step slot is the last prescaler phase in RUN; the BCD value decides step vs terminal.
  assign slot     = (state_q == S_RUN) && (presc_q == PRESC_LAST);
  assign terminal = dir_q ? (count_bcd == 8'h99) : (count_bcd == 8'h00);

  // Next-state and registered-output decode; accepted commands take priority over the step slot.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    done_d  = 1'b0;
    rr_d    = rr_q;

    if (req_a_ready) begin
      rr_d = 1'b1;
    end else if (req_b_ready) begin
      rr_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (acc && is_load_cmd) begin
          state_d = S_LOAD;
          dir_d   = ~cmd[0];
        end else if (acc && cmd == CMD_START) begin
          state_d = S_RUN;
          presc_d = '0;
        end
      end
      S_LOAD: begin
        state_d = S_IDLE;
      end
      S_RUN: begin
        if (acc && is_load_cmd) begin
          state_d = S_LOAD;
          dir_d   = ~cmd[0];
        end else if (acc && cmd == CMD_STOP) begin
          // The STOP cycle still counts as a run cycle, except a slot is frozen so its step is replayed on resume.
          state_d = S_PAUSE;
          if (!slot) begin
            presc_d = presc_q + PRESC_ONE;
          end
        end else if (slot) begin
          presc_d = '0;
          if (terminal) begin
            done_d = 1'b1;
            dir_d  = ~dir_q;
            if (!auto_reverse) begin
              state_d = S_IDLE;
            end
          end else begin
            step_d = 1'b1;
          end
        end else begin
          presc_d = presc_q + PRESC_ONE;
        end
      end
      S_PAUSE: begin
        if (acc && is_load_cmd) begin
          state_d = S_LOAD;
          dir_d   = ~cmd[0];
        end else if (acc && cmd == CMD_START) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    load_d = (state_d == S_LOAD);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      dir_q   <= 1'b1;
      load_q  <= 1'b0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      dir_q   <= dir_d;
      load_q  <= load_d;
      step_q  <= step_d;
      done_q  <= done_d;
      rr_q    <= rr_d;
    end
  end

  assign state       = state_q;
  assign cnt_load    = load_q;
  assign cnt_up_down = dir_q;
  assign cnt_step    = step_q;
  assign done        = done_q;

endmodule

// File: tb/tb_decimal_counter_ctrl.sv
// Bench for decimal_counter_ctrl: directed vector table, multi-cycle sequences, then random traffic vs a reference model.
`timescale 1ns/1ps
module tb_decimal_counter_ctrl;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a_valid, req_b_valid;
  logic [1:0] req_a_cmd, req_b_cmd;
  logic       req_a_ready, req_b_ready;
  logic       auto_reverse;
  logic [7:0] count_bcd;
  logic       cnt_load, cnt_up_down, cnt_step, done;
  logic [1:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  decimal_counter_ctrl #(.PRESCALE(P)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_a_valid (req_a_valid),
    .req_a_cmd   (req_a_cmd),
    .req_a_ready (req_a_ready),
    .req_b_valid (req_b_valid),
    .req_b_cmd   (req_b_cmd),
    .req_b_ready (req_b_ready),
    .auto_reverse(auto_reverse),
    .count_bcd   (count_bcd),
    .cnt_load    (cnt_load),
    .cnt_up_down (cnt_up_down),
    .cnt_step    (cnt_step),
    .done        (done),
    .state       (state)
  );

  always #5 clk = ~clk;

  // Observed output bundle: {state, ready_a, ready_b, load, up_down, step, done}.
  logic [7:0] obs;
  assign obs = {state, req_a_ready, req_b_ready, cnt_load, cnt_up_down, cnt_step, done};

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b  (state,rdyA,rdyB,load,dir,step,done)", name, act, exp);
  endtask

  function automatic logic [7:0] exp8(input logic [1:0] st, input logic ra, input logic rb,
                                      input logic ld, input logic dir, input logic stp, input logic dn);
    return {st, ra, rb, ld, dir, stp, dn};
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    req_a_valid = 1'b0; req_a_cmd = 2'd0;
    req_b_valid = 1'b0; req_b_cmd = 2'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Present one command on A; returns just after the accepting edge.
  task automatic send_a(input logic [1:0] cmd, input string name);
    @(negedge clk);
    req_a_valid = 1'b1;
    req_a_cmd   = cmd;
    #1 check({name, " ready"}, {7'd0, req_a_ready}, 8'd1);
    @(posedge clk);
    #1 req_a_valid = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       av;
    logic [1:0] ac;
    logic       bv;
    logic [1:0] bc;
    logic [7:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic av, input logic [1:0] ac, input logic bv, input logic [1:0] bc,
                              input logic [1:0] st, input logic ra, input logic rb, input logic ld, input logic dir);
    vec_t v;
    v.av = av; v.ac = ac; v.bv = bv; v.bc = bc;
    v.exp = exp8(st, ra, rb, ld, dir, 1'b0, 1'b0);
    return v;
  endfunction

  vec_t vecs[13];

  // ---------------- reference model ----------------
  bit m_running, m_paused, m_loading, m_up, m_favor_b;
  bit m_load, m_step, m_done;
  int m_elapsed;

  task automatic m_init();
    m_running = 0; m_paused = 0; m_loading = 0;
    m_up = 1; m_favor_b = 0;
    m_load = 0; m_step = 0; m_done = 0;
    m_elapsed = 0;
  endtask

  function automatic logic [1:0] m_state();
    if (m_loading) return 2'd1;
    if (m_running) return 2'd2;
    if (m_paused)  return 2'd3;
    return 2'd0;
  endfunction

  // {grant_a, grant_b}
  function automatic logic [1:0] m_grants(input logic av, input logic bv);
    logic ga, gb;
    ga = av && (!bv || !m_favor_b);
    gb = bv && (!av ||  m_favor_b);
    if (m_loading) begin ga = 0; gb = 0; end
    return {ga, gb};
  endfunction

  task automatic m_advance(input logic av, input logic [1:0] ac, input logic bv, input logic [1:0] bc,
                           input logic ar, input logic [7:0] cnt);
    logic [1:0] g;
    logic [1:0] c;
    bit acc, term;
    g   = m_grants(av, bv);
    acc = (g != 2'b00);
    c   = g[1] ? ac : bc;
    m_step = 0; m_done = 0;
    if (g[1]) m_favor_b = 1;
    else if (g[0]) m_favor_b = 0;

    if (m_loading) begin
      m_loading = 0;
    end else if (acc && c[1]) begin
      m_loading = 1; m_running = 0; m_paused = 0;
      m_up = (c == 2'd2);
    end else if (acc && c == 2'd1) begin
      if (m_running) begin
        if (m_elapsed != P - 1) m_elapsed++;
        m_running = 0; m_paused = 1;
      end
    end else if (acc && c == 2'd0 && !m_running) begin
      if (!m_paused) m_elapsed = 0;
      m_running = 1; m_paused = 0;
    end else if (m_running) begin
      if (m_elapsed == P - 1) begin
        m_elapsed = 0;
        term = m_up ? (cnt == 8'h99) : (cnt == 8'h00);
        if (term) begin
          m_done = 1;
          m_up = !m_up;
          if (!ar) m_running = 0;
        end else begin
          m_step = 1;
        end
      end else begin
        m_elapsed++;
      end
    end
    m_load = m_loading;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    bit         pend_a, pend_b;
    logic [1:0] ca, cb, g;
    int         r;

    auto_reverse = 1'b0;
    count_bcd    = 8'h45;

    // Arbitration / LOAD vectors from reset (count 45 keeps away from terminals).
    vecs[0]  = mk(0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 0, 1);
    vecs[1]  = mk(1, 2'd3, 0, 2'd0, 2'd0, 1, 0, 0, 1);
    vecs[2]  = mk(0, 2'd0, 0, 2'd0, 2'd1, 0, 0, 1, 0);
    vecs[3]  = mk(0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 0, 0);
    vecs[4]  = mk(0, 2'd0, 1, 2'd1, 2'd0, 0, 1, 0, 0);
    vecs[5]  = mk(1, 2'd0, 1, 2'd1, 2'd0, 1, 0, 0, 0);
    vecs[6]  = mk(1, 2'd0, 1, 2'd1, 2'd2, 0, 1, 0, 0);
    vecs[7]  = mk(1, 2'd0, 1, 2'd1, 2'd3, 1, 0, 0, 0);
    vecs[8]  = mk(1, 2'd0, 1, 2'd1, 2'd2, 0, 1, 0, 0);
    vecs[9]  = mk(0, 2'd0, 0, 2'd0, 2'd3, 0, 0, 0, 0);
    vecs[10] = mk(1, 2'd2, 0, 2'd0, 2'd3, 1, 0, 0, 0);
    vecs[11] = mk(1, 2'd2, 1, 2'd0, 2'd1, 0, 0, 1, 1);
    vecs[12] = mk(0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 0, 1);

    do_reset();
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      req_a_valid = vecs[i].av; req_a_cmd = vecs[i].ac;
      req_b_valid = vecs[i].bv; req_b_cmd = vecs[i].bc;
      #1 check($sformatf("vec%0d", i), obs, vecs[i].exp);
    end

    // Prescaled stepping from START, non-terminal count.
    do_reset();
    count_bcd = 8'h45; auto_reverse = 1'b0;
    send_a(2'd0, "presc start");
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("presc k%0d", k), obs, exp8(2'd2, 0, 0, 0, 1, (k > 0) && (k % 4 == 0), 0));
    end

    // Terminal 99 going up, stop.
    do_reset();
    count_bcd = 8'h99; auto_reverse = 1'b0;
    send_a(2'd0, "term stop start");
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("term_stop k%0d", k), obs,
            exp8((k < 4) ? 2'd2 : 2'd0, 0, 0, 0, k < 4, 0, k == 4));
    end

    // Terminal 99 going up, auto-reverse: next slot steps downward.
    do_reset();
    count_bcd = 8'h99; auto_reverse = 1'b1;
    send_a(2'd0, "term rev start");
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      check($sformatf("term_rev k%0d", k), obs, exp8(2'd2, 0, 0, 0, k < 4, k == 8, k == 4));
    end

    // STOP two cycles after a step, START ten cycles later.
    do_reset();
    count_bcd = 8'h45; auto_reverse = 1'b0;
    send_a(2'd0, "pause start");
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("pause run k%0d", k), obs, exp8(2'd2, 0, 0, 0, 1, k == 4, 0));
    end
    send_a(2'd1, "pause stop");
    for (int j = 0; j <= 8; j++) begin
      @(negedge clk);
      check($sformatf("paused j%0d", j), obs, exp8(2'd3, 0, 0, 0, 1, 0, 0));
    end
    send_a(2'd0, "pause resume");
    for (int m = 0; m <= 6; m++) begin
      @(negedge clk);
      check($sformatf("resumed m%0d", m), obs, exp8(2'd2, 0, 0, 0, 1, (m == 2) || (m == 6), 0));
    end

    // Asynchronous reset mid-RUN while a step pulse is high.
    do_reset();
    count_bcd = 8'h45;
    send_a(2'd0, "arst start");
    for (int k = 0; k <= 4; k++) @(negedge clk);
    check("arst pre", obs, exp8(2'd2, 0, 0, 0, 1, 1, 0));
    #2 rst = 1'b0;
    #1 check("arst run now", obs, exp8(2'd0, 0, 0, 0, 1, 0, 0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("arst after k%0d", k), obs, exp8(2'd0, 0, 0, 0, 1, 0, 0));
    end

    // Asynchronous reset mid-LOAD.
    send_a(2'd3, "arst load");
    #1 check("arst load pre", obs, exp8(2'd1, 0, 0, 1, 0, 0, 0));
    rst = 1'b0;
    #1 check("arst load now", obs, exp8(2'd0, 0, 0, 0, 1, 0, 0));

    // Random traffic against the reference model.
    do_reset();
    m_init();
    pend_a = 0; pend_b = 0; ca = 2'd0; cb = 2'd0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!pend_a && $urandom_range(3) == 0) begin
        r = $urandom_range(9);
        ca = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 8) ? 2'd2 : 2'd3;
        pend_a = 1;
      end
      if (!pend_b && $urandom_range(3) == 0) begin
        r = $urandom_range(9);
        cb = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 8) ? 2'd2 : 2'd3;
        pend_b = 1;
      end
      req_a_valid = pend_a; req_a_cmd = ca;
      req_b_valid = pend_b; req_b_cmd = cb;
      auto_reverse = 1'($urandom_range(1));
      case ($urandom_range(3))
        0: count_bcd = 8'h99;
        1: count_bcd = 8'h00;
        2: count_bcd = 8'h45;
        default: count_bcd = 8'($urandom);
      endcase
      #1;
      g = m_grants(req_a_valid, req_b_valid);
      check($sformatf("rand cyc%0d", n), obs, {m_state(), g, m_load, m_up, m_step, m_done});
      m_advance(req_a_valid, req_a_cmd, req_b_valid, req_b_cmd, auto_reverse, count_bcd);
      if (g[1]) pend_a = 0;
      if (g[0]) pend_b = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
